// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with same-cycle hits and a
// blocking single-word fill from the memory controller on a miss.
module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [31:0]       maddr_q, maddr_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic              hit;
    logic              fill_we;
    logic              unused_addr_lsb;

    assign req_tag         = imemaddr[31:IDX_W+2];
    assign req_idx         = imemaddr[IDX_W+1:2];
    assign fill_tag        = maddr_q[31:IDX_W+2];
    assign fill_idx        = maddr_q[IDX_W+1:2];
    assign unused_addr_lsb = ^imemaddr[1:0];
    assign hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    // Outputs are gated by nRST so a reset cycle never presents a hit or a
    // memory request, and a fill completing under reset is never installed.
    always_comb begin
        state_d  = state_q;
        maddr_d  = maddr_q;
        valid_d  = valid_q;
        fill_we  = 1'b0;
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        if (nRST) begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        ihit     = 1'b1;
                        imemload = data_q[req_idx];
                    end else if (imemREN) begin
                        maddr_d = {imemaddr[31:2], 2'b00};
                        state_d = FILL;
                    end
                end
                FILL: begin
                    iREN  = 1'b1;
                    iaddr = maddr_q;
                    if (!iwait) begin
                        fill_we           = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        state_d           = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            maddr_q <= 32'h0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, reuse, conflict,
// address change mid-fill, reset mid-fill and misaligned/idle fetches.
module tb_icache;

    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_load;
    logic        ihit;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    int checks = 0;
    int errors = 0;

    icache dut (
        .CLK      (clk),
        .nRST     (nrst),
        .imemREN  (imem_ren),
        .imemaddr (imem_addr),
        .imemload (imem_load),
        .ihit     (ihit),
        .iREN     (iren),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Inputs change 2 time units after the rising edge; outputs are sampled
    // 1 unit after that, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_fill(input logic [31:0] a, input logic [31:0] d);
        imem_ren = 1'b1; imem_addr = a; iwait = 1'b0; iload = d;
        tick();
        tick();
    endtask

    task automatic test_reset();
        nrst = 1'b0; imem_ren = 1'b1; imem_addr = 32'h0; iwait = 1'b1; iload = 32'h0;
        tick();
        tick();
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_ihit got=%b exp=0", ihit); end
        checks++; if (iren !== 1'b0) begin errors++; $display("FAIL rst_iren got=%b exp=0", iren); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rst_iaddr got=%h exp=0", iaddr); end
        checks++; if (imem_load !== 32'h0) begin errors++; $display("FAIL rst_imemload got=%h exp=0", imem_load); end
        nrst = 1'b1; imem_ren = 1'b0;
        #1;
        checks++; if (ihit !== 1'b0 || iren !== 1'b0 || iaddr !== 32'h0 || imem_load !== 32'h0) begin
            errors++; $display("FAIL idle_outputs got ihit=%b iren=%b iaddr=%h load=%h exp all 0",
                               ihit, iren, iaddr, imem_load);
        end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_cold_miss();
        imem_ren = 1'b1; imem_addr = 32'h0; iwait = 1'b1; iload = 32'hDEAD_BEEF;
        #1;
        checks++; if (ihit !== 1'b0 || iren !== 1'b0) begin
            errors++; $display("FAIL cold_lookup got ihit=%b iren=%b exp 0 0", ihit, iren);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            iwait = (i == 3) ? 1'b0 : 1'b1;
            iload = (i == 3) ? 32'h2001_0005 : 32'hDEAD_BEEF;
            #1;
            checks++; if (iren !== 1'b1 || iaddr !== 32'h0 || ihit !== 1'b0) begin
                errors++; $display("FAIL cold_fill_c%0d got iren=%b iaddr=%h ihit=%b exp 1 0 0",
                                   i, iren, iaddr, ihit);
            end
            tick();
        end
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h2001_0005) begin
            errors++; $display("FAIL cold_hit got ihit=%b load=%h exp 1 20010005", ihit, imem_load);
        end
        $display("test_cold_miss done");
    endtask

    task automatic test_hit_reuse();
        for (int i = 0; i < 2; i++) begin
            tick();
            imem_addr = 32'h0;
            #1;
            checks++; if (ihit !== 1'b1 || iren !== 1'b0 || imem_load !== 32'h2001_0005) begin
                errors++; $display("FAIL reuse_c%0d got ihit=%b iren=%b load=%h exp 1 0 20010005",
                                   i, ihit, iren, imem_load);
            end
        end
        tick();
        $display("test_hit_reuse done");
    endtask

    task automatic test_conflict();
        imem_ren = 1'b1; imem_addr = 32'h40; iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conf_miss40 got ihit=%b exp 0", ihit); end
        tick();
        iwait = 1'b0; iload = 32'h1111_0040;
        #1;
        checks++; if (iren !== 1'b1 || iaddr !== 32'h40) begin
            errors++; $display("FAIL conf_fill40 got iren=%b iaddr=%h exp 1 40", iren, iaddr);
        end
        tick();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h1111_0040) begin
            errors++; $display("FAIL conf_hit40 got ihit=%b load=%h exp 1 11110040", ihit, imem_load);
        end
        tick();
        imem_addr = 32'h0;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conf_miss0 got ihit=%b exp 0", ihit); end
        tick();
        iwait = 1'b0; iload = 32'h2001_0005;
        #1;
        checks++; if (iren !== 1'b1 || iaddr !== 32'h0) begin
            errors++; $display("FAIL conf_fill0 got iren=%b iaddr=%h exp 1 0", iren, iaddr);
        end
        tick();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h2001_0005) begin
            errors++; $display("FAIL conf_hit0 got ihit=%b load=%h exp 1 20010005", ihit, imem_load);
        end
        tick();
        $display("test_conflict done");
    endtask

    task automatic test_mid_fill();
        imem_ren = 1'b1; imem_addr = 32'h8; iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL mid_miss8 got ihit=%b exp 0", ihit); end
        tick();
        imem_addr = 32'hC;
        #1;
        checks++; if (iaddr !== 32'h8 || iren !== 1'b1) begin
            errors++; $display("FAIL mid_hold_c0 got iaddr=%h iren=%b exp 8 1", iaddr, iren);
        end
        tick();
        iwait = 1'b0; iload = 32'h0000_0888;
        #1;
        checks++; if (iaddr !== 32'h8 || iren !== 1'b1) begin
            errors++; $display("FAIL mid_hold_c1 got iaddr=%h iren=%b exp 8 1", iaddr, iren);
        end
        tick();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0 || iren !== 1'b0) begin
            errors++; $display("FAIL mid_missC got ihit=%b iren=%b exp 0 0", ihit, iren);
        end
        tick();
        iwait = 1'b0; iload = 32'h0000_0CCC;
        #1;
        checks++; if (iaddr !== 32'hC || iren !== 1'b1) begin
            errors++; $display("FAIL mid_fillC got iaddr=%h iren=%b exp c 1", iaddr, iren);
        end
        tick();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h0000_0CCC) begin
            errors++; $display("FAIL mid_hitC got ihit=%b load=%h exp 1 00000ccc", ihit, imem_load);
        end
        imem_addr = 32'h8;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h0000_0888) begin
            errors++; $display("FAIL mid_hit8 got ihit=%b load=%h exp 1 00000888", ihit, imem_load);
        end
        tick();
        $display("test_mid_fill done");
    endtask

    task automatic test_reset_mid_fill();
        imem_ren = 1'b1; imem_addr = 32'h10; iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmf_miss10 got ihit=%b exp 0", ihit); end
        tick();
        #1;
        checks++; if (iren !== 1'b1 || iaddr !== 32'h10) begin
            errors++; $display("FAIL rmf_fill got iren=%b iaddr=%h exp 1 10", iren, iaddr);
        end
        tick();
        nrst = 1'b0; iwait = 1'b0; iload = 32'h1010_1010;
        tick();
        nrst = 1'b1; iwait = 1'b1;
        #1;
        checks++; if (iren !== 1'b0) begin errors++; $display("FAIL rmf_iren_drop got iren=%b exp 0", iren); end
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmf_not_installed got ihit=%b exp 0", ihit); end
        imem_addr = 32'h0;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmf_inval0 got ihit=%b exp 0", ihit); end
        imem_addr = 32'h8;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmf_inval8 got ihit=%b exp 0", ihit); end
        imem_addr = 32'hC;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmf_invalC got ihit=%b exp 0", ihit); end
        imem_addr = 32'h10;
        tick();
        #1;
        checks++; if (iren !== 1'b1 || iaddr !== 32'h10) begin
            errors++; $display("FAIL rmf_refill got iren=%b iaddr=%h exp 1 10", iren, iaddr);
        end
        iwait = 1'b0; iload = 32'h1010_1010;
        tick();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h1010_1010) begin
            errors++; $display("FAIL rmf_hit10 got ihit=%b load=%h exp 1 10101010", ihit, imem_load);
        end
        tick();
        $display("test_reset_mid_fill done");
    endtask

    task automatic test_misaligned_idle();
        do_fill(32'h4, 32'h4444_4444);
        iwait = 1'b1;
        imem_addr = 32'h6;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h4444_4444 || iren !== 1'b0) begin
            errors++; $display("FAIL mis_hit6 got ihit=%b load=%h iren=%b exp 1 44444444 0",
                               ihit, imem_load, iren);
        end
        imem_ren = 1'b0;
        #1;
        checks++; if (ihit !== 1'b0 || iren !== 1'b0 || imem_load !== 32'h0 || iaddr !== 32'h0) begin
            errors++; $display("FAIL idle_noreq got ihit=%b iren=%b load=%h iaddr=%h exp 0 0 0 0",
                               ihit, iren, imem_load, iaddr);
        end
        imem_addr = 32'h40;
        tick();
        tick();
        #1;
        checks++; if (iren !== 1'b0) begin errors++; $display("FAIL idle_stay got iren=%b exp 0", iren); end
        imem_ren = 1'b1; imem_addr = 32'h4;
        #1;
        checks++; if (ihit !== 1'b1 || imem_load !== 32'h4444_4444) begin
            errors++; $display("FAIL idle_keep4 got ihit=%b load=%h exp 1 44444444", ihit, imem_load);
        end
        tick();
        $display("test_misaligned_idle done");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_reuse();
        test_conflict();
        test_mid_fill();
        test_reset_mid_fill();
        test_misaligned_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
